// File: rtl/or_result_checker.sv
// Response-side checker for the bitwise-OR unit: queues A|B per stimulus, compares returned results in order.
// Optional first-mismatch capture ports are enabled by defining CHECKER_FIRST_FAIL_CAPTURE_EN.
module or_result_checker #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stim_valid,
  input  logic [WIDTH-1:0]         stim_a,
  input  logic [WIDTH-1:0]         stim_b,
  output logic                     stim_ready,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pass_count,
  output logic [CNT_W-1:0]         fail_count,
  output logic                     error,
  output logic                     underflow,
  output logic                     overflow
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]         fail_expected,
  output logic [WIDTH-1:0]         fail_actual
`endif
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LVL_W = PW + 1;
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             match;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  assign stim_ready = (level != LVL_FULL);
  assign push       = stim_valid && stim_ready;
  assign pop        = res_valid && (level != LVL_ZERO);
  assign head       = mem[rd_ptr];
  assign match      = (res_data == head);

  // Expected-value storage carries no reset; entries beyond level are don't-care.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stim_a | stim_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pass_count <= '0;
      fail_count <= '0;
      error      <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        level <= level + LVL_ONE;
      else if (!push && pop)
        level <= level - LVL_ONE;
      if (stim_valid && !stim_ready) overflow <= 1'b1;
      // An empty-queue result never pops, even if a push lands the same cycle.
      if (res_valid && !pop) underflow <= 1'b1;
      if (pop) begin
        if (match) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          error      <= 1'b1;
        end
      end
    end
  end

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  // Only the mismatch that first raises error is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (pop && !match && !error) begin
      fail_expected <= head;
      fail_actual   <= res_data;
    end
  end
`endif

endmodule

// File: tb/tb_or_result_checker.sv
// Bench for or_result_checker: directed scenarios plus randomized traffic against a queue-based reference model.
// Small counter width so saturation is reachable; honours CHECKER_FIRST_FAIL_CAPTURE_EN.
module tb_or_result_checker;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  stim_valid = 1'b0;
  logic [WIDTH-1:0]      stim_a = '0;
  logic [WIDTH-1:0]      stim_b = '0;
  logic                  stim_ready;
  logic                  res_valid = 1'b0;
  logic [WIDTH-1:0]      res_data = '0;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]      pass_count;
  logic [CNT_W-1:0]      fail_count;
  logic                  error;
  logic                  underflow;
  logic                  overflow;
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0]      fail_expected;
  logic [WIDTH-1:0]      fail_actual;
`endif

  or_result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .stim_ready(stim_ready),
    .res_valid(res_valid), .res_data(res_data),
    .level(level), .pass_count(pass_count), .fail_count(fail_count),
    .error(error), .underflow(underflow), .overflow(overflow)
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    , .fail_expected(fail_expected), .fail_actual(fail_actual)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  // Reference model: an in-order list of expected results plus counters and flags.
  logic [WIDTH-1:0] m_q[$];
  int               m_pass, m_fail;
  bit               m_err, m_unf, m_ovf;
  logic [WIDTH-1:0] m_fexp, m_fact;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_pass = 0; m_fail = 0;
    m_err = 0; m_unf = 0; m_ovf = 0;
    m_fexp = '0; m_fact = '0;
  endtask

  task automatic model_step();
    bit do_pop, do_push;
    logic [WIDTH-1:0] e;
    do_pop  = res_valid && (m_q.size() != 0);
    do_push = stim_valid && (m_q.size() < DEPTH);
    if (stim_valid && !do_push) m_ovf = 1;
    if (res_valid && !do_pop) m_unf = 1;
    if (do_pop) begin
      e = m_q.pop_front();
      if (res_data == e) begin
        if (m_pass < CMAX) m_pass++;
      end else begin
        if (m_fail < CMAX) m_fail++;
        if (!m_err) begin
          m_fexp = e;
          m_fact = res_data;
        end
        m_err = 1;
      end
    end
    if (do_push) m_q.push_back(stim_a | stim_b);
  endtask

  // One clock of stimulus: drive, let the edge sample it, advance the model, then go idle.
  task automatic cyc(input bit sv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input bit rv, input logic [WIDTH-1:0] rd);
    stim_valid = sv; stim_a = a; stim_b = b;
    res_valid = rv; res_data = rd;
    @(posedge clk);
    model_step();
    #1;
    stim_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
        chk("stim_ready", stim_ready, (m_q.size() < DEPTH));
        chk("level", level, m_q.size());
        chk("pass_count", pass_count, m_pass);
        chk("fail_count", fail_count, m_fail);
        chk("error", error, m_err);
        chk("underflow", underflow, m_unf);
        chk("overflow", overflow, m_ovf);
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
        chk("fail_expected", fail_expected, m_fexp);
        chk("fail_actual", fail_actual, m_fact);
`endif
      end
    end
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready", stim_ready, 1);
      chk("idle_level", level, 0);
      chk("idle_counts", {pass_count, fail_count}, 0);
      chk("idle_flags", {error, underflow, overflow}, 0);
      idle(1);
    end

    // Matching results
    cyc(1, 16'h0666, 16'h3080, 0, '0);
    cyc(1, 16'h8666, 16'h0000, 0, '0);
    cyc(0, '0, '0, 1, 16'h36E6);
    idle(2);
    cyc(0, '0, '0, 1, 16'h8666);
    chk("match_pass", pass_count, 2);
    chk("match_model_pass", m_pass, 2);
    chk("match_fail", fail_count, 0);
    chk("match_error", error, 0);
    chk("match_level", level, 0);

    // Mismatch
    cyc(1, 16'h0666, 16'h3080, 0, '0);
    cyc(0, '0, '0, 1, 16'h36E7);
    chk("mis_fail", fail_count, 1);
    chk("mis_error", error, 1);
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    chk("mis_fexp", fail_expected, 16'h36E6);
    chk("mis_fact", fail_actual, 16'h36E7);
`endif
    cyc(1, 16'h0001, 16'h0000, 0, '0);
    cyc(0, '0, '0, 1, 16'h0000);
    chk("mis2_fail", fail_count, 2);
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    chk("mis2_fexp_held", fail_expected, 16'h36E6);
    chk("mis2_fact_held", fail_actual, 16'h36E7);
`endif

    // Full / overflow
    for (int i = 1; i <= 4; i++) cyc(1, 16'(i << 4), 16'(i), 0, '0);
    chk("full_ready", stim_ready, 0);
    chk("full_level", level, 4);
    cyc(1, 16'hFFFF, 16'h0000, 0, '0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 4);
    for (int i = 1; i <= 4; i++) cyc(0, '0, '0, 1, 16'(i * 16'h11));
    chk("drain_pass", pass_count, 6);
    chk("drain_level", level, 0);

    // Underflow and simultaneous push/pop
    cyc(0, '0, '0, 1, 16'h1234);
    chk("unf_flag", underflow, 1);
    chk("unf_counts", {pass_count, fail_count}, {4'd6, 4'd2});
    cyc(1, 16'h00F0, 16'h0F00, 0, '0);
    cyc(1, 16'h1234, 16'h0001, 1, 16'h0FF0);
    chk("sim_level", level, 1);
    chk("sim_pass", pass_count, 7);

    // Async reset mid-stream
    do_reset();
    cyc(1, 16'h0001, 16'h0002, 0, '0);
    cyc(1, 16'h0004, 16'h0008, 0, '0);
    cyc(1, 16'h0010, 16'h0020, 0, '0);
    cyc(1, 16'h0040, 16'h0080, 0, '0);
    cyc(0, '0, '0, 1, 16'hDEAD);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_fail", fail_count, 1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_level", level, 0);
    chk("arst_counts", {pass_count, fail_count}, 0);
    chk("arst_flags", {error, underflow, overflow}, 0);
    chk("arst_ready", stim_ready, 1);
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    chk("arst_capture", {fail_expected, fail_actual}, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      cyc(1, 16'(i), 16'h0000, 0, '0);
      cyc(0, '0, '0, 1, 16'(i));
    end
    chk("sat_pass", pass_count, CMAX);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 16'(i), 16'h0100, 0, '0);
      cyc(0, '0, '0, 1, ~(16'(i) | 16'h0100));
    end
    chk("sat_fail", fail_count, CMAX);
    chk("sat_error", error, 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [WIDTH-1:0] a, b, rd;
      bit sv, rv;
      a  = 16'($urandom);
      b  = 16'($urandom);
      sv = ($urandom_range(0, 99) < 50);
      rv = ($urandom_range(0, 99) < 45);
      if (m_q.size() != 0 && $urandom_range(0, 7) != 0)
        rd = m_q[0];
      else
        rd = 16'($urandom);
      cyc(sv, a, b, rv, rd);
    end
    idle(2);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
